// File: rtl/card_dealer_if.sv
// Draw request / dealt-card bundle between the game controller and card_dealer.
interface card_dealer_if;
  localparam int unsigned VAL_W = 4;
  localparam int unsigned CNT_W = 6;

  logic             pip;
  logic             new_deck;
  logic [VAL_W-1:0] number;
  logic [CNT_W-1:0] cards_left;
  logic             refill;

  modport master (
    output pip,
    output new_deck,
    input  number,
    input  cards_left,
    input  refill
  );

  modport slave (
    input  pip,
    input  new_deck,
    output number,
    output cards_left,
    output refill
  );
endinterface

// File: rtl/card_dealer.sv
// 52-card register deck dealt without replacement; LFSR-scaled index, swap-with-last removal,
// automatic reload on exhaustion or request.
module card_dealer #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter bit          RANDOM = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  card_dealer_if.slave bus
);
  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANKS     = 13;
  localparam int unsigned VAL_W     = 4;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned RND_W     = 8;
  localparam int unsigned PROD_W    = RND_W + CNT_W;
  // A zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  function automatic logic [VAL_W-1:0] image_val(input int unsigned i);
    return VAL_W'((i % RANKS) + 1);
  endfunction

  logic [VAL_W-1:0]  deck [DECK_SIZE];
  logic [VAL_W-1:0]  eff  [DECK_SIZE];
  logic [LFSR_W-1:0] lfsr;

  logic              reload_c;
  logic [CNT_W-1:0]  n_c;
  logic [RND_W-1:0]  rnd_c;
  logic [PROD_W-1:0] prod_c;
  logic [IDX_W-1:0]  idx_c;
  logic [IDX_W-1:0]  last_c;
  logic [VAL_W-1:0]  pick_c;
  logic [VAL_W-1:0]  last_val_c;

  // Effective deck for this cycle and the scaled draw index (rnd * n) >> 8.
  always_comb begin
    reload_c = bus.new_deck || (bus.cards_left == '0);
    n_c      = reload_c ? CNT_W'(DECK_SIZE) : bus.cards_left;
    rnd_c    = RANDOM ? lfsr[RND_W-1:0] : '0;
    prod_c   = PROD_W'(rnd_c) * PROD_W'(n_c);
    idx_c    = IDX_W'(prod_c >> RND_W);
    last_c   = IDX_W'(n_c - CNT_W'(1));
    for (int unsigned i = 0; i < DECK_SIZE; i++) begin
      eff[i] = reload_c ? image_val(i) : deck[i];
    end
    pick_c     = eff[idx_c];
    last_val_c = eff[last_c];
  end

  // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1; advances every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[LFSR_W-1:1]};
    end
  end

  // Deck storage: the drawn slot is backfilled with the last live card.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DECK_SIZE; i++) begin
        deck[i] <= image_val(i);
      end
    end else if (bus.pip) begin
      for (int unsigned i = 0; i < DECK_SIZE; i++) begin
        deck[i] <= (IDX_W'(i) == idx_c) ? last_val_c : eff[i];
      end
    end else if (bus.new_deck) begin
      for (int unsigned i = 0; i < DECK_SIZE; i++) begin
        deck[i] <= image_val(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.number     <= '0;
      bus.cards_left <= CNT_W'(DECK_SIZE);
      bus.refill     <= 1'b0;
    end else begin
      bus.refill <= bus.pip && (bus.cards_left == '0) && !bus.new_deck;
      if (bus.pip) begin
        bus.number     <= pick_c;
        bus.cards_left <= CNT_W'(last_c);
      end else if (bus.new_deck) begin
        bus.cards_left <= CNT_W'(DECK_SIZE);
      end
    end
  end
endmodule

// File: tb/tb_card_dealer.sv
// Random and deterministic card_dealer instances driven in lockstep and checked against
// a deck-as-array model of the dealing rules.
module tb_card_dealer;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pip = 1'b0;
  logic new_deck = 1'b0;

  always #5 clk = ~clk;

  card_dealer_if bus_r ();
  card_dealer_if bus_d ();

  assign bus_r.pip      = pip;
  assign bus_r.new_deck = new_deck;
  assign bus_d.pip      = pip;
  assign bus_d.new_deck = new_deck;

  card_dealer #(.SEED(SEED), .RANDOM(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));
  card_dealer #(.SEED(SEED), .RANDOM(1'b0)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

  int vectors = 0;
  int miscompares = 0;

  // Model state; index 0 is the random instance, 1 the deterministic one.
  logic [15:0] m_lfsr;
  int m_deck [2][52];
  int m_left [2];
  int m_num [2];
  int m_refill [2];
  int cnt [16];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 52; i++) m_deck[k][i] = i % 13 + 1;
      m_left[k]   = 52;
      m_num[k]    = 0;
      m_refill[k] = 0;
    end
  endtask

  task automatic model_step(input bit p, input bit nd);
    int rnd, n, idx, old_left;
    for (int k = 0; k < 2; k++) begin
      rnd      = (k == 0) ? int'(m_lfsr[7:0]) : 0;
      old_left = m_left[k];
      n        = (nd || old_left == 0) ? 52 : old_left;
      if ((p || nd) && (nd || old_left == 0))
        for (int i = 0; i < 52; i++) m_deck[k][i] = i % 13 + 1;
      if (p) begin
        idx            = (rnd * n) / 256;
        m_num[k]       = m_deck[k][idx];
        m_deck[k][idx] = m_deck[k][n-1];
        m_left[k]      = n - 1;
      end else if (nd) begin
        m_left[k] = 52;
      end
      m_refill[k] = (p && old_left == 0 && !nd) ? 1 : 0;
    end
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  task automatic compare_all();
    check("rnd.number", int'(bus_r.number), m_num[0]);
    check("rnd.left", int'(bus_r.cards_left), m_left[0]);
    check("rnd.refill", int'(bus_r.refill), m_refill[0]);
    check("det.number", int'(bus_d.number), m_num[1]);
    check("det.left", int'(bus_d.cards_left), m_left[1]);
    check("det.refill", int'(bus_d.refill), m_refill[1]);
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 time unit later.
  task automatic cycle(input bit p, input bit nd);
    pip      = p;
    new_deck = nd;
    @(posedge clk);
    model_step(p, nd);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic int det_expect(input int j);
    return (j == 0) ? 1 : 13 - ((j - 1) % 13);
  endfunction

  int held;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst.number", int'(bus_r.number), 0);
    check("rst.left", int'(bus_r.cards_left), 52);
    check("rst.refill", int'(bus_r.refill), 0);
    repeat (100) cycle(1'b0, 1'b0);

    // Full deck at random spacing.
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int j = 0; j < 52; j++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      check("det.seq", int'(bus_d.number), det_expect(j));
      check("det.step", int'(bus_d.cards_left), 51 - j);
      check("rnd.range", (bus_r.number >= 4'd1 && bus_r.number <= 4'd13) ? 1 : 0, 1);
      cnt[bus_r.number]++;
    end
    for (int v = 1; v <= 13; v++) check("rnd.count", cnt[v], 4);

    // Exhausted deck: next draw refills in the same cycle.
    cycle(1'b1, 1'b0);
    check("auto.refill", int'(bus_r.refill), 1);
    check("auto.left", int'(bus_r.cards_left), 51);
    check("auto.range", (bus_r.number >= 4'd1 && bus_r.number <= 4'd13) ? 1 : 0, 1);
    cycle(1'b0, 1'b0);
    check("auto.pulse", int'(bus_r.refill), 0);

    repeat (9) cycle(1'b1, 1'b0);
    held = int'(bus_r.number);
    cycle(1'b0, 1'b1);
    check("nd.left", int'(bus_r.cards_left), 52);
    check("nd.hold", int'(bus_r.number), held);
    cycle(1'b1, 1'b1);
    check("ndpip.left", int'(bus_r.cards_left), 51);
    check("ndpip.refill", int'(bus_r.refill), 0);

    // Reset asserted between edges in the middle of a burst.
    repeat (5) cycle(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.number", int'(bus_r.number), 0);
    check("arst.left", int'(bus_r.cards_left), 52);
    check("arst.refill", int'(bus_r.refill), 0);
    check("arst.dleft", int'(bus_d.cards_left), 52);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 52; j++) begin
      cycle(1'b1, 1'b0);
      check("arst.seq", int'(bus_d.number), det_expect(j));
    end

    repeat (300) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
